// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings as seen on the op port and the control FSM state type.
package muldiv_pkg;

   // Operation select; bit 1 distinguishes divide from multiply.
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   // Control FSM: CALC runs one iteration per cycle, FIX applies signs.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

   // True for the two-operand signed operations.
   function automatic logic isSignedOp(input op_e opSel);
      return (opSel == OP_MULT) || (opSel == OP_DIV);
   endfunction

   // True for the two divide operations.
   function automatic logic isDivOp(input op_e opSel);
      return (opSel == OP_DIV) || (opSel == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. Multiplication is radix-2 shift-add and
// division is restoring, both on operand magnitudes, one step per CALC
// cycle; signs are restored in FIX. A single hi/lo pair carries either the
// 2*WIDTH product or the remainder/quotient, so no separate HI/LO select
// is needed downstream.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   // Counter holds 0..WIDTH so it never wraps inside an operation.
   localparam int CW = $clog2(WIDTH + 1);

   // Control and operand state.
   state_e           state;
   op_e              opReg;
   logic [WIDTH-1:0] accHi;      // product upper half / partial remainder
   logic [WIDTH-1:0] accLo;      // multiplier shifting out / dividend -> quotient
   logic [WIDTH-1:0] opB;        // multiplicand / divisor magnitude
   logic             negResult;  // product or quotient must be negated
   logic             negDividend;// remainder must be negated
   logic [CW-1:0]    count;

   // Start-time decode of the port operands.
   op_e              opIn;
   logic             signedIn;
   logic             aNeg;
   logic             bNeg;
   logic [WIDTH-1:0] aMag;
   logic [WIDTH-1:0] bMag;
   logic             divByZero;

   // One iteration step and the sign-corrected result.
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divTrial;
   logic [WIDTH-1:0]   stepHi;
   logic [WIDTH-1:0]   stepLo;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   fixHi;
   logic [WIDTH-1:0]   fixLo;

   // Decode operands on the port side so an accepted start captures magnitudes directly.
   always_comb begin
      // NOTE: every variable gets a default at the top of a combinational block so no path leaves it unassigned, which would infer a latch.
      opIn      = op_e'(op);
      signedIn  = isSignedOp(opIn);
      aNeg      = signedIn && a[WIDTH-1];
      bNeg      = signedIn && b[WIDTH-1];
      aMag      = aNeg ? (~a + 1'b1) : a;
      bMag      = bNeg ? (~b + 1'b1) : b;
      divByZero = isDivOp(opIn) && (b == '0);
   end

   // Single shift-add or restoring-divide step selected by the captured op.
   always_comb begin
      mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
      divShift = {accHi, accLo[WIDTH-1]};
      divTrial = divShift - {1'b0, opB};
      stepHi   = mulSum[WIDTH:1];
      stepLo   = {mulSum[0], accLo[WIDTH-1:1]};
      if (isDivOp(opReg)) begin
         // Top bit of the trial difference set means the divisor did not fit.
         if (!divTrial[WIDTH]) begin
            stepHi = divTrial[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], 1'b1};
         end else begin
            stepHi = divShift[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Sign correction: product negated on sign mismatch, quotient truncated
   // toward zero, remainder follows the dividend.
   always_comb begin
      product = {accHi, accLo};
      if (negResult) begin
         product = ~product + 1'b1;
      end
      fixHi = product[2*WIDTH-1:WIDTH];
      fixLo = product[WIDTH-1:0];
      if (isDivOp(opReg)) begin
         fixLo = negResult   ? (~accLo + 1'b1) : accLo;
         fixHi = negDividend ? (~accHi + 1'b1) : accHi;
      end
   end

   // Control FSM with registered outputs and the iterating datapath.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values of the others.
      if (reset) begin
         state       <= IDLE;
         opReg       <= OP_MULT;
         accHi       <= '0;
         accLo       <= '0;
         opB         <= '0;
         negResult   <= 1'b0;
         negDividend <= 1'b0;
         count       <= '0;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_zero    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opReg       <= opIn;
                  accHi       <= '0;
                  accLo       <= aMag;
                  opB         <= bMag;
                  negResult   <= aNeg ^ bNeg;
                  negDividend <= aNeg;
                  count       <= '0;
                  busy        <= 1'b1;
                  if (divByZero) begin
                     // Divide by zero bypasses the iterations entirely.
                     hi       <= a;
                     lo       <= '1;
                     div_zero <= 1'b1;
                     done     <= 1'b1;
                     state    <= DONE;
                  end else begin
                     div_zero <= 1'b0;
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               accHi <= stepHi;
               accLo <= stepLo;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               hi    <= fixHi;
               lo    <= fixLo;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32: directed corner cases
// followed by random operations, compared against a 64-bit arithmetic model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         div_zero;

   int numVectors = 0;
   int numMiscompares = 0;

   // Results the DUT should still be showing from the previous operation.
   logic [W-1:0] prevHi = '0;
   logic [W-1:0] prevLo = '0;
   logic         prevDz = 1'b0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      numVectors++;
      if (got !== exp) begin
         numMiscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference results from plain 64-bit arithmetic.
   function automatic void model(input logic [1:0] opSel, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] expHi, output logic [W-1:0] expLo,
                                 output logic expDz);
      longint sx = $signed(x);
      longint sy = $signed(y);
      logic [63:0] ux = {32'd0, x};
      logic [63:0] uy = {32'd0, y};
      logic [63:0] r;
      logic [63:0] q;
      expDz = 1'b0;
      expHi = '0;
      expLo = '0;
      if (opSel[1] && y == 0) begin
         expDz = 1'b1;
         expHi = x;
         expLo = '1;
      end else begin
         case (opSel)
            2'b00: begin r = sx * sy; expHi = r[63:32]; expLo = r[31:0]; end
            2'b01: begin r = ux * uy; expHi = r[63:32]; expLo = r[31:0]; end
            2'b10: begin q = sx / sy; r = sx % sy; expHi = r[31:0]; expLo = q[31:0]; end
            default: begin q = ux / uy; r = ux % uy; expHi = r[31:0]; expLo = q[31:0]; end
         endcase
      end
   endfunction

   // Runs one operation; optionally pokes start mid-flight and in the DONE cycle.
   task automatic runOp(input logic [1:0] opSel, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit busyPoke, input bit donePoke, input string name);
      logic [W-1:0] expHi;
      logic [W-1:0] expLo;
      logic         expDz;
      int           edges;
      int           expLat;
      model(opSel, x, y, expHi, expLo, expDz);
      expLat = expDz ? 0 : W + 1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b1;
      op = opSel;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 0;
      while (!done && edges < 100) begin
         checkVal({name, ".busy"}, busy, 1);
         checkVal({name, ".hiHold"}, hi, prevHi);
         checkVal({name, ".loHold"}, lo, prevLo);
         checkVal({name, ".dzClr"}, div_zero, 0);
         if (busyPoke && edges == 5) begin
            start = 1'b1;
            op = ~opSel;
            a = $urandom;
            b = $urandom;
         end
         if (edges == 6) begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         edges++;
      end
      start = 1'b0;
      checkVal({name, ".latency"}, edges, expLat);
      checkVal({name, ".hi"}, hi, expHi);
      checkVal({name, ".lo"}, lo, expLo);
      checkVal({name, ".divZero"}, div_zero, expDz);
      checkVal({name, ".busyDone"}, busy, 1);
      if (donePoke) begin
         start = 1'b1;
         op = 2'b01;
         a = $urandom;
         b = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      checkVal({name, ".donePulse"}, done, 0);
      checkVal({name, ".idle"}, busy, 0);
      @(posedge clk);
      #1;
      checkVal({name, ".idleBusy"}, busy, 0);
      checkVal({name, ".hiKeep"}, hi, expHi);
      checkVal({name, ".loKeep"}, lo, expLo);
      checkVal({name, ".dzKeep"}, div_zero, expDz);
      prevHi = expHi;
      prevLo = expLo;
      prevDz = expDz;
   endtask

   // Checks the cleared state expected right after reset.
   task automatic checkReset(input string name);
      checkVal({name, ".busy"}, busy, 0);
      checkVal({name, ".done"}, done, 0);
      checkVal({name, ".hi"}, hi, 0);
      checkVal({name, ".lo"}, lo, 0);
      checkVal({name, ".divZero"}, div_zero, 0);
      prevHi = '0;
      prevLo = '0;
      prevDz = 1'b0;
   endtask

   initial begin
      logic [1:0]   rOp;
      logic [W-1:0] rA;
      logic [W-1:0] rB;
      int           sel;
      int           sawDone;

      // Reset coinciding with start: reset must win.
      reset = 1'b1;
      start = 1'b1;
      op = 2'b00;
      a = 32'd3;
      b = 32'd4;
      repeat (3) @(posedge clk);
      #1;
      checkReset("resetStart");

      // Directed corner cases; the first start lands in the first cycle after reset.
      runOp(2'b00, 32'hFFFF_FFFD, 32'd7,        1'b0, 1'b0, "multNeg");
      runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "multuMax");
      runOp(2'b10, 32'hFFFF_FFF9, 32'd2,        1'b0, 1'b1, "divNeg");
      runOp(2'b11, 32'd100,       32'd7,        1'b0, 1'b0, "divu");
      runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "divMinNeg1");
      runOp(2'b10, 32'd5,         32'd0,        1'b0, 1'b1, "divZero");
      runOp(2'b10, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, "divPosNeg");
      runOp(2'b11, 32'd9,         32'd0,        1'b0, 1'b0, "divuZero");

      // Abort at iteration 10: no done pulse, everything cleared.
      @(negedge clk);
      start = 1'b1;
      op = 2'b00;
      a = 32'd1234;
      b = 32'd5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      sawDone = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) sawDone++;
      end
      checkVal("abort.noDone", sawDone, 0);
      checkReset("abort");

      // Random operations with occasional corner operands.
      for (int i = 0; i < 40; i++) begin
         rOp = 2'($urandom_range(0, 3));
         rA = $urandom;
         rB = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: rB = '0;
            1: begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
            2: rB = $urandom_range(1, 15);
            3: rA = $urandom_range(0, 300);
            default: ;
         endcase
         runOp(rOp, rA, rB, (i % 5) == 1, (i % 7) == 3, $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
